// File: rtl/if_stage.sv
// Instruction-fetch stage of the miniRV core: holds the PC, issues one
// instruction-memory read at a time and hands the returned word to decode.
//
// state | meaning
// ------+--------------------------------------------------------------
// REQ   | request valid at pc, waiting for the memory to accept it
// WAIT  | one request outstanding, waiting for its response
// HOLD  | fetched word presented to decode, waiting for id_ready
module if_stage #(
    parameter int                XLEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_inst,
    output logic [6:0]      id_opcode
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] ALIGN_MASK = ~{{(XLEN-2){1'b0}}, 2'b11};
    localparam logic [XLEN-1:0] PC_STEP    = {{(XLEN-3){1'b0}}, 3'd4};

    state_t          state;
    logic [XLEN-1:0] pc;
    logic            drop;
    logic [XLEN-1:0] redirect_target;

    assign redirect_target = redirect_pc & ALIGN_MASK;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_REQ;
            pc      <= RESET_PC;
            drop    <= 1'b0;
            id_pc   <= '0;
            id_inst <= '0;
        end else begin
            case (state)
                S_REQ: begin
                    if (redirect_valid) begin
                        pc <= redirect_target;
                    end
                    // A request accepted alongside a redirect fetches the old
                    // address, so its response must be thrown away.
                    if (imem_req_ready) begin
                        state <= S_WAIT;
                        drop  <= redirect_valid;
                    end
                end
                S_WAIT: begin
                    if (redirect_valid) begin
                        pc <= redirect_target;
                        if (imem_rsp_valid) begin
                            drop  <= 1'b0;
                            state <= S_REQ;
                        end else begin
                            drop  <= 1'b1;
                        end
                    end else if (imem_rsp_valid) begin
                        if (drop) begin
                            drop  <= 1'b0;
                            state <= S_REQ;
                        end else begin
                            id_inst <= imem_rsp_data;
                            id_pc   <= pc;
                            pc      <= pc + PC_STEP;
                            state   <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (redirect_valid) begin
                        pc    <= redirect_target;
                        state <= S_REQ;
                    end else if (id_ready) begin
                        state <= S_REQ;
                    end
                end
                default: begin
                    state <= S_REQ;
                end
            endcase
        end
    end

    // Valids come straight from the state register, gated only by reset.
    assign imem_req_valid = (state == S_REQ) && !rst;
    assign id_valid       = (state == S_HOLD) && !rst;
    assign imem_req_addr  = pc;
    assign id_opcode      = id_inst[6:0];

endmodule
